pipe_stage_buf: RTL and testbench



---
 rtl/pipe_stage_buf_pkg.sv | 13 +
 rtl/pipe_stage_buf_sat_counter.sv | 33 +++
 rtl/pipe_stage_buf.sv | 124 ++++++++++++
 tb/tb_pipe_stage_buf.sv | 137 +++++++++++++
 4 files changed

// File: rtl/pipe_stage_buf_pkg.sv
// Shared definitions for the inter-stage pipeline register (pipe_stage_buf).
package defs;

  localparam int          BIN_DIG  = 32;
  localparam logic [31:0] NOP_INST = 32'h13;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } pipe_state_t;

endpackage

// File: rtl/pipe_stage_buf_sat_counter.sv
// Saturating event counter with synchronous clear; clear beats increment.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// Valid/ready pipeline stage register with flush bubble and stall counter.
// Define PIPE_SKID_EN to add a skid entry and a registered in_ready.
module pipe_stage_buf
  import defs::*;
#(
  parameter int               WIDTH     = BIN_DIG,
  parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(NOP_INST),
  parameter int               CNT_W     = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             flush,
  input  logic             clr_stats,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] stall_cnt
);

  pipe_state_t      state_q, state_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic             valid_q;
  logic             push, pop;

`ifdef PIPE_SKID_EN
  logic [WIDTH-1:0] s_q, s_d;
  logic             rdy_q;

  assign in_ready = rdy_q;
`else
  // Without the skid entry a pop frees the slot in the same cycle.
  assign in_ready = !valid_q || out_ready;
`endif

  assign push = in_valid && in_ready;
  assign pop  = valid_q && out_ready;

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
`ifdef PIPE_SKID_EN
    s_d     = s_q;
`endif
    case (state_q)
      EMPTY: begin
        if (push) begin
          m_d     = in_data;
          state_d = FULL;
        end
      end
      FULL: begin
        if (push && pop) begin
          m_d = in_data;
`ifdef PIPE_SKID_EN
        end else if (push) begin
          s_d     = in_data;
          state_d = SKID;
`endif
        end else if (pop) begin
          m_d     = RESET_VAL;
          state_d = EMPTY;
        end
      end
`ifdef PIPE_SKID_EN
      SKID: begin
        if (pop) begin
          m_d     = s_q;
          s_d     = RESET_VAL;
          state_d = FULL;
        end
      end
`endif
      default: begin
        m_d     = RESET_VAL;
        state_d = EMPTY;
      end
    endcase
    // Flush drops any accepted push but the downstream pop still completes.
    if (flush) begin
      state_d = EMPTY;
      m_d     = RESET_VAL;
`ifdef PIPE_SKID_EN
      s_d     = RESET_VAL;
`endif
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= EMPTY;
      m_q     <= RESET_VAL;
      valid_q <= 1'b0;
`ifdef PIPE_SKID_EN
      s_q     <= RESET_VAL;
      rdy_q   <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      valid_q <= (state_d != EMPTY);
`ifdef PIPE_SKID_EN
      s_q     <= s_d;
      rdy_q   <= (state_d != SKID);
`endif
    end
  end

  assign out_valid = valid_q;
  assign out_data  = m_q;

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk  (CLK),
    .rst_n(RST),
    .inc  (valid_q && !out_ready),
    .clr  (clr_stats),
    .count(stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed scoreboard bench for pipe_stage_buf (either PIPE_SKID_EN build).
module tb_pipe_stage_buf;

  localparam int          W     = 32;
  localparam int          CW    = 4;
  localparam logic [31:0] RST_V = 32'h13;
`ifdef PIPE_SKID_EN
  localparam int          CAP   = 2;
`else
  localparam int          CAP   = 1;
`endif

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          flush = 1'b0, clr_stats = 1'b0;
  logic          in_valid = 1'b0, out_ready = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          in_ready, out_valid;
  logic [W-1:0]  out_data;
  logic [CW-1:0] stall_cnt;

  int            total = 0;
  int            bad = 0;
  logic [31:0]   sbq[$];
  int            exp_stall = 0;

  always #5 CLK = ~CLK;

  pipe_stage_buf #(.WIDTH(W), .CNT_W(CW)) dut (
    .CLK(CLK), .RST(RST), .flush(flush), .clr_stats(clr_stats),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .stall_cnt(stall_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One cycle: drive, compare against the model, clock, update the model.
  task automatic tick(input logic iv, input logic [31:0] d, input logic ordy,
                      input logic fl = 1'b0, input logic clr = 1'b0);
    logic ev, er, do_pop, do_push;
    in_valid = iv; in_data = d; out_ready = ordy; flush = fl; clr_stats = clr;
    #1;
    ev = (sbq.size() != 0);
    er = (CAP == 2) ? (sbq.size() < 2) : (!ev || ordy);
    check("in_ready", {31'b0, in_ready}, {31'b0, er});
    check("out_valid", {31'b0, out_valid}, {31'b0, ev});
    check("out_data", out_data, ev ? sbq[0] : RST_V);
    check("stall_cnt", {28'b0, stall_cnt}, exp_stall);
    do_pop  = ev && ordy;
    do_push = iv && er && !fl;
    $display("step iv=%0b d=%h ordy=%0b fl=%0b clr=%0b -> ov=%0b od=%h ir=%0b sc=%0d",
             iv, d, ordy, fl, clr, out_valid, out_data, in_ready, stall_cnt);
    @(posedge CLK);
    if (do_pop) void'(sbq.pop_front());
    if (fl) sbq.delete();
    else if (do_push) sbq.push_back(d);
    if (clr) exp_stall = 0;
    else if (ev && !ordy && exp_stall != 15) exp_stall++;
    @(negedge CLK);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ov"}, {31'b0, out_valid}, 32'd0);
    check({tag, "_od"}, out_data, RST_V);
    check({tag, "_ir"}, {31'b0, in_ready}, 32'd1);
    check({tag, "_sc"}, {28'b0, stall_cnt}, 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check_reset_vals("reset");
    RST = 1'b1;
    tick(0, 0, 1);

    // Streaming at full rate.
    for (int i = 0; i < 8; i++) tick(1, 32'hA0 + i, 1);
    tick(0, 0, 1);
    tick(0, 0, 1);

    // Back-pressure.
    tick(1, 32'h11, 0);
    tick(1, 32'h22, 0);
    tick(0, 0, 0);
    tick(0, 0, 0);
`ifdef PIPE_SKID_EN
    tick(0, 0, 1);
    tick(0, 0, 1);
`else
    tick(1, 32'h22, 1);
    tick(0, 0, 1);
`endif
    tick(0, 0, 1);

    // Flush with a simultaneous push, then flush with a simultaneous pop.
    tick(1, 32'h55, 0);
    tick(1, 32'h66, 0, 1);
    tick(0, 0, 1);
    tick(1, 32'h77, 0);
    tick(0, 0, 1, 1);
    tick(0, 0, 1);

    // Saturation and clear.
    tick(0, 0, 1, 0, 1);
    tick(1, 32'h99, 0);
    for (int i = 0; i < 20; i++) tick(0, 0, 0);
    check("sat_15", {28'b0, stall_cnt}, 32'd15);
    tick(0, 0, 0, 0, 1);
    tick(0, 0, 1);
    tick(0, 0, 1);

    // Asynchronous reset while holding data.
    tick(1, 32'hC1, 0);
    tick(1, 32'hC2, 0);
    in_valid = 1'b0; out_ready = 1'b0;
    #2 RST = 1'b0;
    #1 check_reset_vals("midrst");
    sbq.delete();
    exp_stall = 0;
    @(negedge CLK);
    RST = 1'b1;
    tick(1, 32'hD0, 1);
    tick(0, 0, 1);
    tick(0, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
